// File: rtl/bsg_counter_set_en_ctrl_if.sv
// Configuration handshake and downstream counter bus for bsg_counter_set_en_ctrl.
// The slave side is the controller; the master side is the environment that
// supplies configurations and hosts the downstream set/enable counter.
interface bsg_counter_set_en_ctrl_if #(
    parameter int width_p = 3
);

    // configuration handshake
    logic               cfg_v_i;
    logic [width_p-1:0] cfg_start_i;
    logic [width_p-1:0] cfg_limit_i;
    logic               cfg_ready_o;

    // downstream counter control and returned count
    logic               set_o;
    logic [width_p-1:0] val_o;
    logic               en_o;
    logic [width_p-1:0] count_i;

    modport master (
        output cfg_v_i,
        output cfg_start_i,
        output cfg_limit_i,
        input  cfg_ready_o,
        input  set_o,
        input  val_o,
        input  en_o,
        output count_i
    );

    modport slave (
        input  cfg_v_i,
        input  cfg_start_i,
        input  cfg_limit_i,
        output cfg_ready_o,
        output set_o,
        output val_o,
        output en_o,
        input  count_i
    );

endinterface

// File: rtl/bsg_counter_set_en_ctrl.sv
// Controller that drives a downstream set/enable counter: loads a start value,
// issues prescaled increment strobes while run_i is high, and pulses hit_o and
// auto-reloads once the returned count equals the programmed limit.
// Outputs are combinational from state, registers and inputs so that the
// downstream counter reacts in the same cycle the decision is made.

// Property checker kept apart from the datapath.
module bsg_counter_set_en_ctrl_chk (
    input logic clk_i,
    input logic reset_i,
    input logic set_o,
    input logic en_o,
    input logic hit_o,
    input logic busy_o,
    input logic cfg_ready_o
);

    // load and increment strobes are mutually exclusive
    a_set_en_excl: assert property (@(posedge clk_i) disable iff (reset_i)
        !(set_o && en_o));

    // no strobes or hits while idle
    a_idle_quiet: assert property (@(posedge clk_i) disable iff (reset_i)
        !busy_o |-> !(set_o || en_o || hit_o));

    // configuration is never accepted while loading
    a_load_not_ready: assert property (@(posedge clk_i) disable iff (reset_i)
        set_o |-> !cfg_ready_o);

    // a terminal-count hit never coincides with an increment
    a_hit_no_en: assert property (@(posedge clk_i) disable iff (reset_i)
        hit_o |-> !en_o);

    // every hit is followed by a reload unless reset intervenes
    a_hit_reload: assert property (@(posedge clk_i) disable iff (reset_i)
        hit_o |=> (set_o || reset_i));

endmodule

module bsg_counter_set_en_ctrl #(
    parameter int width_p    = 3,
    parameter int prescale_p = 2
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       run_i,
    bsg_counter_set_en_ctrl_if.slave   ctrl_bus,
    output logic                       hit_o,
    output logic                       busy_o
);

    // A single-phase prescaler still needs a 1-bit register; it simply stays 0.
    localparam int ps_w_lp = (prescale_p > 1) ? $clog2(prescale_p) : 1;
    localparam logic [ps_w_lp-1:0] ps_last_lp = ps_w_lp'(prescale_p - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_e;

    state_e               state_r;
    state_e               state_nxt_s;
    logic [width_p-1:0]   start_r;
    logic [width_p-1:0]   limit_r;
    logic [ps_w_lp-1:0]   ps_r;
    logic [ps_w_lp-1:0]   ps_nxt_s;

    logic                 cfg_ready_s;
    logic                 cfg_accept_s;
    logic                 at_limit_s;
    logic                 set_s;
    logic                 en_s;
    logic                 hit_s;

    // Loading is the only state that refuses a new configuration.
    assign cfg_ready_s  = (state_r != LOAD);
    assign cfg_accept_s = ctrl_bus.cfg_v_i & cfg_ready_s;

    // Terminal count compares the counter's registered value, so wrap-around
    // past the maximum value is handled naturally by the modulo arithmetic.
    assign at_limit_s   = (ctrl_bus.count_i == limit_r);

    // Next-state, prescaler and strobe decode; configuration accept wins last.
    always_comb begin
        state_nxt_s = state_r;
        ps_nxt_s    = ps_r;
        set_s       = 1'b0;
        en_s        = 1'b0;
        hit_s       = 1'b0;

        case (state_r)
            IDLE: begin
                state_nxt_s = IDLE;
            end

            LOAD: begin
                set_s       = 1'b1;
                ps_nxt_s    = {ps_w_lp{1'b0}};
                state_nxt_s = RUN;
            end

            RUN: begin
                if (at_limit_s) begin
                    // terminal count: report it and reload, independent of run_i
                    hit_s       = 1'b1;
                    state_nxt_s = LOAD;
                end else if (run_i) begin
                    en_s = (ps_r == ps_last_lp);
                    if (ps_r == ps_last_lp) begin
                        ps_nxt_s = {ps_w_lp{1'b0}};
                    end else begin
                        ps_nxt_s = ps_r + ps_w_lp'(1'b1);
                    end
                end else begin
                    // paused: prescale phase is frozen so it resumes unchanged
                    ps_nxt_s = ps_r;
                end
            end

            default: begin
                state_nxt_s = IDLE;
                ps_nxt_s    = {ps_w_lp{1'b0}};
            end
        endcase

        if (cfg_accept_s) begin
            state_nxt_s = LOAD;
        end else begin
            state_nxt_s = state_nxt_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Prescale phase counter.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ps_r <= {ps_w_lp{1'b0}};
        end else begin
            ps_r <= ps_nxt_s;
        end
    end

    // Start/limit capture on every accepted configuration.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            start_r <= {width_p{1'b0}};
            limit_r <= {width_p{1'b0}};
        end else if (cfg_accept_s) begin
            start_r <= ctrl_bus.cfg_start_i;
            limit_r <= ctrl_bus.cfg_limit_i;
        end else begin
            start_r <= start_r;
            limit_r <= limit_r;
        end
    end

    assign ctrl_bus.cfg_ready_o = cfg_ready_s;
    assign ctrl_bus.set_o       = set_s;
    assign ctrl_bus.val_o       = start_r;
    assign ctrl_bus.en_o        = en_s;
    assign hit_o                = hit_s;
    assign busy_o               = (state_r != IDLE);

    bsg_counter_set_en_ctrl_chk u_chk (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .set_o       (set_s),
        .en_o        (en_s),
        .hit_o       (hit_s),
        .busy_o      (busy_o),
        .cfg_ready_o (cfg_ready_s)
    );

endmodule

// File: doc/bsg_counter_set_en_ctrl.md
BSG_COUNTER_SET_EN_CTRL -- requirements
Module: bsg_counter_set_en_ctrl

Interface
REQ-001 Parameter width_p, default 3: width of count, start and limit values.
REQ-002 Parameter prescale_p, default 2, legal range >=1: RUN-state cycles with run_i=1 per increment request.
REQ-003 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 reset_i  in  1  reset, synchronous and active-high.
REQ-005 cfg_v_i  in  1  new configuration valid.
REQ-006 cfg_start_i  in  width_p  value loaded into the downstream counter at each (re)load.
REQ-007 cfg_limit_i  in  width_p  terminal count value.
REQ-008 cfg_ready_o  out  1  configuration accepted when cfg_v_i & cfg_ready_o.
REQ-009 run_i  in  1  level enable for counting.
REQ-010 set_o  out  1  load strobe to the downstream counter.
REQ-011 val_o  out  width_p  load value to the downstream counter.
REQ-012 en_o  out  1  increment strobe to the downstream counter.
REQ-013 count_i  in  width_p  registered count returned by the downstream counter, which updates one cycle after set_o or en_o.
REQ-014 hit_o  out  1  one-cycle terminal-count pulse.
REQ-015 busy_o  out  1  high whenever state != IDLE.

Function
REQ-016 The FSM SHALL have three states: IDLE, LOAD, RUN.
REQ-017 Registers SHALL be start_r, limit_r and a prescale counter ps_r, which wraps from prescale_p-1 to 0.
REQ-018 cfg_ready_o SHALL be 1 in IDLE and RUN and 0 in LOAD.
REQ-019 On a configuration accept, the block SHALL capture start_r/limit_r and enter LOAD next cycle from any state.
REQ-020 A configuration accept SHALL take priority over every other transition.
REQ-021 LOAD behaviour:
  - set_o=1 and en_o=0.
  - ps_r cleared.
  - next state RUN unconditionally.
REQ-022 val_o SHALL equal start_r at all times; it is qualified only by set_o.
REQ-023 In RUN, at_limit SHALL be defined as (count_i == limit_r).
REQ-024 In RUN with at_limit=1, the block SHALL:
  - assert hit_o=1 and en_o=0;
  - enter LOAD next cycle (auto-reload), unless a configuration accept occurs in the same cycle, in which case it enters LOAD with the new values and hit_o is still 1.
REQ-025 In RUN with at_limit=0 and run_i=1:
  - en_o = (ps_r == prescale_p-1);
  - ps_r advances by one with wrap.
REQ-026 In RUN with run_i=0, en_o SHALL be 0 and ps_r SHALL hold, so the prescale phase resumes unchanged.
REQ-027 hit_o SHALL be evaluated regardless of run_i.
REQ-028 The limit SHALL be reached modulo 2^width_p: when limit < start, counting passes through max and 0 before the hit.
REQ-029 start == limit SHALL hit in the first RUN cycle, giving a 2-cycle period with en_o never asserted.
REQ-030 set_o and en_o SHALL never both be 1.
REQ-031 set_o, en_o and hit_o SHALL all be 0 in IDLE.
REQ-032 For prescale_p=1, ps_r SHALL be width 1 and constant 0, so en_o = run_i in RUN when not at limit.
REQ-033 All outputs SHALL be combinational functions of state, registers and inputs; no output register stage SHALL be added.

Reset
REQ-034 While reset_i=1 at a clock edge, the next state SHALL be IDLE with start_r=0, limit_r=0 and ps_r=0.
REQ-035 Reset values: set_o=0, en_o=0, hit_o=0, busy_o=0, val_o=0, cfg_ready_o=1.
REQ-036 Reset SHALL override any configuration accept in the same cycle.
REQ-037 Reset asserted mid-RUN or mid-LOAD SHALL abort with no residual strobes; the downstream counter shares reset_i.

Verification (width_p=3, prescale_p=2, bench models the downstream counter: set has priority over en, reset to 0)
REQ-038 Scenario: reset held 2 cycles -> cfg_ready_o=1, busy_o=0, set_o=en_o=hit_o=0, count 0.
REQ-039 Scenario: cfg start=1, limit=3, run_i=1 -> next cycle set_o=1/val_o=1, en_o every 2nd RUN cycle, count 1,2,3; hit_o pulses once at count 3, then set_o reloads 1; pattern repeats.
REQ-040 Scenario: start=6, limit=1 -> count sequence 6,7,0,1; hit_o at 1 only (wrap check).
REQ-041 Scenario: start=limit=5 -> hit_o every 2 cycles, en_o never 1, set_o/hit_o alternating.
REQ-042 Scenario: run_i dropped for 3 cycles mid-RUN with ps_r=1 -> en_o=0, count frozen; first run_i=1 cycle asserts en_o immediately.
REQ-043 Scenario: cfg start=2, limit=4 accepted in the hit cycle -> hit_o=1, next set_o has val_o=2. Then reset mid-RUN -> next cycle IDLE, all strobes 0.
